// File: rtl/alg_amba_vip_apb4demux_if.sv
// Upstream APB4 bus between a requester and the demux.
// The demux connects through the slave modport.
interface alg_amba_vip_apb4demux_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/alg_amba_vip_apb4demux.sv
// APB4 1-to-N demultiplexer: window decode, registered completion, decode-error
// response, completer timeout and sticky interrupt aggregation.
module alg_amba_vip_apb4demux #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter bit DECERR_EN      = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  alg_amba_vip_apb4demux_if.slave                 up,
  output logic                                    pintreq,
  input  logic                                    int_clr,
  output logic                                    timeout_evt,
  input  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]   slv_address_begin,
  input  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]   slv_address_end,
  input  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]   slv_address_mask,
  output logic [NUM_SLAVES-1:0]                   slv_psel,
  output logic [NUM_SLAVES-1:0]                   slv_penable,
  output logic [NUM_SLAVES-1:0]                   slv_pwrite,
  output logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]   slv_paddr,
  output logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]   slv_pwdata,
  output logic [NUM_SLAVES-1:0][DATA_WIDTH/8-1:0] slv_pstrb,
  output logic [NUM_SLAVES-1:0][2:0]              slv_pprot,
  input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]   slv_prdata,
  input  logic [NUM_SLAVES-1:0]                   slv_pready,
  input  logic [NUM_SLAVES-1:0]                   slv_pslverr,
  input  logic [NUM_SLAVES-1:0]                   slv_pintreq
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int ID_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                 state;
  logic                   pwrite_q;
  logic [ADDR_WIDTH-1:0]  paddr_q;
  logic [DATA_WIDTH-1:0]  pwdata_q;
  logic [STRB_W-1:0]      pstrb_q;
  logic [2:0]             pprot_q;
  logic [ID_W-1:0]        id_q;
  logic                   noone_q;
  logic                   psel_q;
  logic                   penable_q;
  logic [DATA_WIDTH-1:0]  prdata_q;
  logic                   pready_q;
  logic                   pslverr_q;
  logic                   tevt_q;
  logic [CNT_W-1:0]       cnt;

  logic                   hit_any;
  logic [ID_W-1:0]        hit_id;
  logic [ADDR_WIDTH-1:0]  hit_addr;
  logic                   sel_pready;
  logic                   sel_pslverr;
  logic [DATA_WIDTH-1:0]  sel_prdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Descending scan so the lowest-index hit is the one left standing.
  always_comb begin
    hit_any  = 1'b0;
    hit_id   = '0;
    hit_addr = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (up.paddr >= slv_address_begin[i] && up.paddr < slv_address_end[i]) begin
        hit_any  = 1'b1;
        hit_id   = ID_W'(i);
        hit_addr = up.paddr & slv_address_mask[i];
      end
    end
  end

  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (id_q == ID_W'(i)) begin
        sel_pready  = slv_pready[i];
        sel_pslverr = slv_pslverr[i];
        sel_prdata  = slv_prdata[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      id_q      <= '0;
      noone_q   <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      tevt_q    <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (up.psel) begin
            pwrite_q <= up.pwrite;
            pwdata_q <= up.pwdata;
            pstrb_q  <= up.pstrb;
            pprot_q  <= up.pprot;
            id_q     <= hit_id;
            noone_q  <= ~hit_any;
            paddr_q  <= hit_addr;
            psel_q   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (up.penable) begin
            penable_q <= 1'b1;
            cnt       <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (noone_q) begin
            pready_q  <= 1'b1;
            pslverr_q <= DECERR_EN;
            prdata_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state     <= RESP;
          end else if (sel_pready) begin
            pready_q  <= 1'b1;
            pslverr_q <= sel_pslverr;
            prdata_q  <= sel_prdata;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state     <= RESP;
          end else if (TIMEOUT_CYCLES != 0 && cnt == TO_LAST) begin
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= '0;
            tevt_q    <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state     <= RESP;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        RESP: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          tevt_q    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new interrupt takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pintreq <= 1'b0;
    end else if (|slv_pintreq) begin
      pintreq <= 1'b1;
    end else if (int_clr) begin
      pintreq <= 1'b0;
    end
  end

  always_comb begin
    slv_psel    = '0;
    slv_penable = '0;
    slv_pwrite  = '0;
    slv_paddr   = '0;
    slv_pwdata  = '0;
    slv_pstrb   = '0;
    slv_pprot   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!noone_q && id_q == ID_W'(i)) begin
        slv_psel[i]    = psel_q;
        slv_penable[i] = penable_q;
        slv_pwrite[i]  = pwrite_q;
        slv_paddr[i]   = paddr_q;
        slv_pwdata[i]  = pwdata_q;
        slv_pstrb[i]   = pwrite_q ? pstrb_q : '0;
        slv_pprot[i]   = pprot_q;
      end
    end
  end

  assign up.prdata   = prdata_q;
  assign up.pready   = pready_q;
  assign up.pslverr  = pslverr_q;
  assign timeout_evt = tevt_q;

endmodule

// File: tb/tb_alg_amba_vip_apb4demux.sv
// Scoreboard bench for the APB4 demux: two instances differing only in the
// decode-error response, driven by one requester and a small slave model.
module tb_alg_amba_vip_apb4demux;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alg_amba_vip_apb4demux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0();
  alg_amba_vip_apb4demux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1();
  assign bus1.psel    = bus0.psel;
  assign bus1.penable = bus0.penable;
  assign bus1.pwrite  = bus0.pwrite;
  assign bus1.paddr   = bus0.paddr;
  assign bus1.pwdata  = bus0.pwdata;
  assign bus1.pstrb   = bus0.pstrb;
  assign bus1.pprot   = bus0.pprot;

  logic pintreq0, pintreq1, tevt0, tevt1, int_clr;
  logic [NS-1:0][AW-1:0] wbeg, wend, wmask;
  logic [NS-1:0] s_psel, s_penable, s_pwrite, s1_psel, s1_penable, s1_pwrite;
  logic [NS-1:0][AW-1:0] s_paddr, s1_paddr;
  logic [NS-1:0][DW-1:0] s_pwdata, s1_pwdata, s_rdata;
  logic [NS-1:0][DW/8-1:0] s_pstrb, s1_pstrb;
  logic [NS-1:0][2:0] s_pprot, s1_pprot;
  logic [NS-1:0] s_pready, s_err, s_irq, never, late;
  int waits [NS];
  int wcnt [NS];

  alg_amba_vip_apb4demux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
    .TIMEOUT_CYCLES(4), .DECERR_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .up(bus0.slave), .pintreq(pintreq0), .int_clr(int_clr),
    .timeout_evt(tevt0), .slv_address_begin(wbeg), .slv_address_end(wend),
    .slv_address_mask(wmask), .slv_psel(s_psel), .slv_penable(s_penable),
    .slv_pwrite(s_pwrite), .slv_paddr(s_paddr), .slv_pwdata(s_pwdata),
    .slv_pstrb(s_pstrb), .slv_pprot(s_pprot), .slv_prdata(s_rdata),
    .slv_pready(s_pready), .slv_pslverr(s_err), .slv_pintreq(s_irq));

  alg_amba_vip_apb4demux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
    .TIMEOUT_CYCLES(4), .DECERR_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .up(bus1.slave), .pintreq(pintreq1), .int_clr(int_clr),
    .timeout_evt(tevt1), .slv_address_begin(wbeg), .slv_address_end(wend),
    .slv_address_mask(wmask), .slv_psel(s1_psel), .slv_penable(s1_penable),
    .slv_pwrite(s1_pwrite), .slv_paddr(s1_paddr), .slv_pwdata(s1_pwdata),
    .slv_pstrb(s1_pstrb), .slv_pprot(s1_pprot), .slv_prdata(s_rdata),
    .slv_pready(s_pready), .slv_pslverr(s_err), .slv_pintreq(s_irq));

  // Slave model: ready after waits[i] ACCESS cycles unless it never answers.
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++)
      wcnt[i] <= (s_psel[i] && s_penable[i]) ? wcnt[i] + 1 : 0;
  end
  always_comb begin
    s_pready = '0;
    for (int i = 0; i < NS; i++)
      s_pready[i] = (s_psel[i] & s_penable[i] & (wcnt[i] >= waits[i]) & ~never[i]) | late[i];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tevt;
    int          cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // Monitor: every upstream completion must match the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus0.pready) begin
        if (q0.size() == 0) check("dut0_unexpected_pready", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          check("dut0_prdata", bus0.prdata, e.rdata);
          check("dut0_pslverr", 32'(bus0.pslverr), 32'(e.err));
          check("dut0_timeout_evt", 32'(tevt0), 32'(e.tevt));
          check("dut0_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (bus0.pslverr || tevt0) check("dut0_stray_flag", 32'd1, 32'd0);
      if (bus1.pready) begin
        if (q1.size() == 0) check("dut1_unexpected_pready", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("dut1_prdata", bus1.prdata, e.rdata);
          check("dut1_pslverr", 32'(bus1.pslverr), 32'(e.err));
          check("dut1_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic xfer(input string name, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                      input int sel, input logic [31:0] spaddr, input logic [31:0] erd,
                      input logic eerr0, input logic eerr1, input logic etevt, input int lat);
    exp_t e;
    logic [NS-1:0] vec;
    int oth;
    vec = (sel >= 0) ? NS'(1 << sel) : '0;
    e.rdata = erd; e.err = eerr0; e.tevt = etevt; e.cyc = cyc + lat;
    q0.push_back(e);
    e.err = eerr1;
    q1.push_back(e);
    bus0.psel = 1'b1; bus0.penable = 1'b0; bus0.pwrite = wr; bus0.paddr = addr;
    bus0.pwdata = wdata; bus0.pstrb = strb; bus0.pprot = prot;
    @(posedge clk); #1;
    check({name, "_setup_psel"}, 32'(s_psel), 32'(vec));
    check({name, "_setup_penable"}, 32'(s_penable), 32'd0);
    bus0.penable = 1'b1;
    @(posedge clk); #1;
    check({name, "_access_penable"}, 32'(s_penable), 32'(vec));
    if (sel >= 0) begin
      oth = 1 - sel;
      check({name, "_paddr"}, s_paddr[sel], spaddr);
      check({name, "_pwdata"}, s_pwdata[sel], wdata);
      check({name, "_pstrb"}, 32'(s_pstrb[sel]), wr ? 32'(strb) : 32'd0);
      check({name, "_pprot"}, 32'(s_pprot[sel]), 32'(prot));
      check({name, "_pwrite"}, 32'(s_pwrite[sel]), 32'(wr));
      check({name, "_other_port"}, s_paddr[oth] | s_pwdata[oth] |
            32'({s_psel[oth], s_penable[oth], s_pwrite[oth], s_pstrb[oth], s_pprot[oth]}), 32'd0);
    end else begin
      check({name, "_no_port"}, s_paddr[0] | s_paddr[1] | s_pwdata[0] | s_pwdata[1], 32'd0);
    end
    for (int k = 0; k < 20 && !bus0.pready; k++) begin
      @(posedge clk); #1;
    end
    if (!bus0.pready) check({name, "_completion_seen"}, 32'd0, 32'd1);
    bus0.psel = 1'b0; bus0.penable = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycles %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.psel = 0; bus0.penable = 0; bus0.pwrite = 0; bus0.paddr = '0;
    bus0.pwdata = '0; bus0.pstrb = '0; bus0.pprot = '0;
    int_clr = 0; s_irq = '0; never = '0; late = '0; s_err = '0; s_rdata = '0;
    waits[0] = 0; waits[1] = 0;
    wbeg[0] = 32'h0000;  wend[0] = 32'h1000; wmask[0] = 32'hFFF;
    wbeg[1] = 32'h1000;  wend[1] = 32'h2000; wmask[1] = 32'hFFF;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pready", 32'(bus0.pready), 32'd0);
    check("rst_prdata", bus0.prdata, 32'd0);
    check("rst_pintreq", 32'(pintreq0), 32'd0);
    check("rst_slv_psel", 32'(s_psel), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    s_rdata[1] = 32'h1111_2222;
    xfer("wr_s1", 1'b1, 32'h1234, 32'hA5A5_0001, 4'h5, 3'd3, 1, 32'h234,
         32'h1111_2222, 1'b0, 1'b0, 1'b0, 3);

    waits[0] = 2; s_rdata[0] = 32'hDEAD_BEEF; s_err[0] = 1'b1;
    xfer("rd_s0_wait", 1'b0, 32'h0010, 32'h0, 4'hF, 3'd0, 0, 32'h010,
         32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 5);

    waits[0] = 0; s_err[0] = 1'b0; s_rdata[0] = 32'h0000_0800;
    wend[0] = 32'h2000; wmask[0] = 32'h1FFF;
    xfer("overlap", 1'b0, 32'h1800, 32'h0, 4'h0, 3'd1, 0, 32'h1800,
         32'h0000_0800, 1'b0, 1'b0, 1'b0, 3);
    wend[0] = 32'h1000; wmask[0] = 32'hFFF;

    xfer("unmapped", 1'b0, 32'hFFFF_0000, 32'h0, 4'h0, 3'd0, -1, 32'h0,
         32'h0, 1'b1, 1'b0, 1'b0, 3);

    never[1] = 1'b1;
    xfer("timeout", 1'b1, 32'h1004, 32'h1234_5678, 4'hF, 3'd0, 1, 32'h004,
         32'h0, 1'b1, 1'b1, 1'b1, 6);
    late[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 late[1] = 1'b0; never[1] = 1'b0;
    s_rdata[1] = 32'h5555_AAAA;
    xfer("after_timeout", 1'b0, 32'h1008, 32'h0, 4'h0, 3'd2, 1, 32'h008,
         32'h5555_AAAA, 1'b0, 1'b0, 1'b0, 3);

    check("irq_idle", 32'(pintreq0), 32'd0);
    s_irq = 2'b10;
    check("irq_not_yet", 32'(pintreq0), 32'd0);
    @(posedge clk); #1 s_irq = '0;
    check("irq_set", 32'(pintreq0), 32'd1);
    @(posedge clk); #1;
    check("irq_sticky", 32'(pintreq0), 32'd1);
    int_clr = 1'b1;
    @(posedge clk); #1 int_clr = 1'b0;
    check("irq_clr", 32'(pintreq0), 32'd0);
    int_clr = 1'b1; s_irq = 2'b10;
    @(posedge clk); #1 int_clr = 1'b0; s_irq = '0;
    check("irq_set_wins", 32'(pintreq0), 32'd1);

    waits[0] = 10;
    bus0.psel = 1'b1; bus0.pwrite = 1'b0; bus0.paddr = 32'h0020; bus0.pstrb = 4'h0;
    @(posedge clk); #1 bus0.penable = 1'b1;
    @(posedge clk); #1;
    check("rstmid_in_access", 32'(s_penable), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_psel", 32'(s_psel), 32'd0);
    check("rstmid_penable", 32'(s_penable), 32'd0);
    check("rstmid_paddr", s_paddr[0], 32'd0);
    check("rstmid_prdata", bus0.prdata, 32'd0);
    check("rstmid_pintreq", 32'(pintreq0), 32'd0);
    check("rstmid_flags", 32'({bus0.pready, bus0.pslverr, tevt0}), 32'd0);
    @(posedge clk); #1;
    bus0.psel = 1'b0; bus0.penable = 1'b0; rst = 1'b0; waits[0] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
